washer_plant_model: RTL
=======================

Name: washer_plant_model

Overview:
- Plant/sensor-side counterpart to the washing-machine controller `auto_machine`.
- Consumes the controller's actuator outputs and generates its sensor inputs: `filled`, `detergent_added`, `cycle_timeout`, `drained`, `spin_timeout`.
- Models water level, detergent dispensing and wash/spin durations with counters, so the controller can run closed-loop in simulation and in FPGA demos without hand-driven stimulus.

Parameters:
- LEVEL_MAX, 8: full-tank water level, in level units.
- FILL_RATE, 4: clocks per level unit while filling or draining (≥1).
- DET_CYCLES, 6: clocks from `soap_wash` rise to `detergent_added`.
- WASH_CYCLES, 20: clocks of wash motor run before `cycle_timeout`.
- SPIN_CYCLES, 12: clocks of spin motor run before `spin_timeout`.
- TIMER_W, 16: width of every internal timer; all *_CYCLES values must be < 2^TIMER_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- door_lock  in  1  controller door-lock command.
- motor_on  in  1  controller motor command.
- fill_value_on  in  1  fill-valve command.
- drain_value_on  in  1  drain-valve command.
- soap_wash  in  1  controller is in its soap phase.
- water_wash  in  1  controller is in its rinse phase.
- done  in  1  controller cycle complete.
- filled  out  1  tank at LEVEL_MAX.
- detergent_added  out  1  detergent dispensed.
- cycle_timeout  out  1  wash duration elapsed.
- drained  out  1  tank empty.
- spin_timeout  out  1  spin duration elapsed.
- fault  out  1  sticky plant fault; exists only with the optional feature, else tied 0.

Behaviour:
- Reset (reset=0, asynchronous): level=0, all timers=0.
  - Outputs: `filled`=0, `detergent_added`=0, `cycle_timeout`=0, `spin_timeout`=0, `fault`=0, `drained`=1.
  - Reset mid-operation discards all progress; no output glitch other than going to these reset values.
- All outputs are registered. Each flag reflects the state committed on the same edge, i.e. it asserts the same cycle its condition becomes true in registers.
- Level model (rate counter 0..FILL_RATE-1):
  - Fill only: the rate counter increments each clock. On reaching FILL_RATE-1 it wraps to 0 and the level increments, saturating at LEVEL_MAX.
  - Drain only: same counting, but the level decrements, saturating at 0.
  - Neither valve, or both valves on: level and rate counter hold.
  - `filled` = (level==LEVEL_MAX); `drained` = (level==0).
  - Fill at LEVEL_MAX or drain at 0: no change, rate counter held at 0.
- Detergent:
  - Rising edge of `soap_wash` with `detergent_added`=0 starts a DET_CYCLES countdown.
  - At expiry, `detergent_added`=1 and stays set.
  - Cleared when `water_wash`=1 or `done`=1; a clear in the same cycle as expiry wins.
  - A `soap_wash` drop before expiry aborts the countdown.
- Motor timers:
  - Wash mode = `motor_on` & (level>0).
  - Spin mode = `motor_on` & (level==0) & `door_lock`.
  - The active mode's timer increments. Its flag asserts when the count reaches the *_CYCLES value; the count then saturates and the flag stays 1.
  - `motor_on`=0, or a switch to the other mode, clears that timer and its flag on the next edge.
  - Wash and spin flags are never both 1.
- `done`=1 clears all timers and all flags except `drained`/`filled`, which track level.

Optional Feature:
- Macro WASHER_PLANT_FAULT_EN.
- Defined: `fault` sets and stays set until reset when any of these is true:
  - `fill_value_on` & `drain_value_on`.
  - `motor_on` & !`door_lock`.
  - `fill_value_on` while `filled`=1 for more than FILL_RATE consecutive clocks (overflow).
- Undefined: `fault` is a constant 0 and no fault logic is generated.

Decomposition:
- Shared package `washer_pkg`:
  - Default cycle-count localparams.
  - Level-width function (clog2 of LEVEL_MAX+1).
  - Mode encoding: IDLE, WASH, SPIN.
- One natural sub-module, `plant_timer`: a parameterised saturating up-counter with enable, synchronous clear and a reached-target flag. It is instantiated three times (detergent, wash, spin).

Test Plan:
- Reset, all inputs 0 -> `drained`=1, every other output 0. Release reset, hold inputs 20 clocks -> no change.
- `fill_value_on`=1 with defaults -> `filled`=1 exactly 32 clocks later and `drained`=0 after 4 clocks. Then `drain_value_on`=1 only -> `drained`=1 after 32 clocks.
- Level 8, `soap_wash` rise -> `detergent_added`=1 on the 6th clock. `water_wash`=1 -> cleared next edge.
- `motor_on`=1 at level 8 -> `cycle_timeout` at clock 20, held. Drain to 0 with `door_lock`=1 and `motor_on` held -> `cycle_timeout` clears, `spin_timeout` at clock 12 of spin.
- Reset asserted mid-fill at level 5 -> immediate `drained`=1, level 0. After release, a fill takes the full 32 clocks again.
- With WASHER_PLANT_FAULT_EN, both valves on for 1 clock -> `fault`=1 and stays set until reset. Without the macro, the same stimulus -> `fault`=0 and level holds.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared defaults, mode encoding and width helper for the washer plant model.
package washer_pkg;

  localparam int unsigned LEVEL_MAX_DEF   = 8;
  localparam int unsigned FILL_RATE_DEF   = 4;
  localparam int unsigned DET_CYCLES_DEF  = 6;
  localparam int unsigned WASH_CYCLES_DEF = 20;
  localparam int unsigned SPIN_CYCLES_DEF = 12;
  localparam int unsigned TIMER_W_DEF     = 16;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_WASH = 2'd1,
    MODE_SPIN = 2'd2
  } mode_e;

  // Bits needed to hold a water level in 0..level_max.
  function automatic int unsigned level_width(input int unsigned level_max);
    return $clog2(level_max + 1);
  endfunction

endpackage

// File: rtl/plant_timer.sv
// Saturating up-counter with enable, synchronous clear and registered reached-target flag.
// TARGET must be >= 1 and < 2**W.
module plant_timer #(
  parameter int unsigned W      = 16,
  parameter int unsigned TARGET = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic hit_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         hit_q, hit_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != W'(TARGET))) begin
      cnt_d = cnt_q + W'(1);
    end
    hit_d = !clr_i && (cnt_d == W'(TARGET));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/washer_plant_model.sv
// Plant-side sensor model for the washing-machine controller: tank level, detergent and motor timers.
// Optional sticky plant fault detection is built only when WASHER_PLANT_FAULT_EN is defined.
module washer_plant_model
  import washer_pkg::*;
#(
  parameter int unsigned LEVEL_MAX   = LEVEL_MAX_DEF,
  parameter int unsigned FILL_RATE   = FILL_RATE_DEF,
  parameter int unsigned DET_CYCLES  = DET_CYCLES_DEF,
  parameter int unsigned WASH_CYCLES = WASH_CYCLES_DEF,
  parameter int unsigned SPIN_CYCLES = SPIN_CYCLES_DEF,
  parameter int unsigned TIMER_W     = TIMER_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic door_lock,
  input  logic motor_on,
  input  logic fill_value_on,
  input  logic drain_value_on,
  input  logic soap_wash,
  input  logic water_wash,
  input  logic done,
  output logic filled,
  output logic detergent_added,
  output logic cycle_timeout,
  output logic drained,
  output logic spin_timeout,
  output logic fault
);

  localparam int unsigned LW = level_width(LEVEL_MAX);
  localparam int unsigned RW = (FILL_RATE > 1) ? $clog2(FILL_RATE) : 1;

  logic [LW-1:0] level_q, level_d;
  logic [RW-1:0] rate_q, rate_d;
  logic          filled_q, filled_d;
  logic          drained_q, drained_d;
  logic          at_max, at_min, unit_tick;

  assign at_max    = (level_q == LW'(LEVEL_MAX));
  assign at_min    = (level_q == '0);
  assign unit_tick = (rate_q == RW'(FILL_RATE - 1));

  // Level moves one unit every FILL_RATE clocks of a single open valve.
  always_comb begin
    level_d = level_q;
    rate_d  = rate_q;
    if ((fill_value_on && !drain_value_on && at_max) ||
        (drain_value_on && !fill_value_on && at_min)) begin
      rate_d = '0;
    end else if (fill_value_on != drain_value_on) begin
      rate_d = unit_tick ? '0 : rate_q + RW'(1);
      if (unit_tick) begin
        level_d = fill_value_on ? level_q + LW'(1) : level_q - LW'(1);
      end
    end
    filled_d  = (level_d == LW'(LEVEL_MAX));
    drained_d = (level_d == '0);
  end

  mode_e mode;

  always_comb begin
    mode = MODE_IDLE;
    if (motor_on && !at_min) begin
      mode = MODE_WASH;
    end else if (motor_on && door_lock) begin
      mode = MODE_SPIN;
    end
  end

  logic soap_q;
  logic det_run_q, det_run_d;
  logic det_hit, det_rise, det_clr, det_en;

  // A soap drop only aborts a countdown that has not yet expired.
  assign det_rise  = soap_wash && !soap_q && !det_hit;
  assign det_clr   = water_wash || done || (!soap_wash && !det_hit);
  assign det_en    = det_rise || det_run_q;
  assign det_run_d = !det_clr && (det_run_q || det_rise);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q   <= '0;
      rate_q    <= '0;
      filled_q  <= 1'b0;
      drained_q <= 1'b1;
      soap_q    <= 1'b0;
      det_run_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      rate_q    <= rate_d;
      filled_q  <= filled_d;
      drained_q <= drained_d;
      soap_q    <= soap_wash;
      det_run_q <= det_run_d;
    end
  end

  plant_timer #(.W(TIMER_W), .TARGET(DET_CYCLES)) u_det_timer (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (det_en),
    .clr_i (det_clr),
    .hit_o (det_hit)
  );

  plant_timer #(.W(TIMER_W), .TARGET(WASH_CYCLES)) u_wash_timer (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (mode == MODE_WASH),
    .clr_i (done || (mode != MODE_WASH)),
    .hit_o (cycle_timeout)
  );

  plant_timer #(.W(TIMER_W), .TARGET(SPIN_CYCLES)) u_spin_timer (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (mode == MODE_SPIN),
    .clr_i (done || (mode != MODE_SPIN)),
    .hit_o (spin_timeout)
  );

  assign filled          = filled_q;
  assign drained         = drained_q;
  assign detergent_added = det_hit;

`ifdef WASHER_PLANT_FAULT_EN
  localparam int unsigned OW = $clog2(FILL_RATE + 2);

  logic [OW-1:0] ovf_q, ovf_d;
  logic          fault_q, fault_d;

  // Overflow: fill held against a full tank for more than FILL_RATE clocks.
  always_comb begin
    ovf_d = '0;
    if (fill_value_on && filled_q) begin
      ovf_d = (ovf_q == OW'(FILL_RATE + 1)) ? ovf_q : ovf_q + OW'(1);
    end
    fault_d = fault_q ||
              (fill_value_on && drain_value_on) ||
              (motor_on && !door_lock) ||
              (ovf_d > OW'(FILL_RATE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule
